// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write register file.
package regfile_pkg;

    localparam int unsigned REGFILE_DATA_W   = 32;
    localparam int unsigned REGFILE_ADDR_W   = 5;
    localparam int unsigned REGFILE_ZERO_IDX = 0;

    typedef logic [REGFILE_ADDR_W-1:0] reg_spec_t;

endpackage

// File: rtl/regfile_wr_decoder.sv
// One-hot row write-enable decoder: ADDR_W specifier to 2**ADDR_W rows, with enable.
module regfile_wr_decoder
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = REGFILE_ADDR_W
) (
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic                     en_i,
    output logic [(1<<ADDR_W)-1:0]   row_we_o
);

    // At most one row is selected; none when disabled.
    always_comb begin
        row_we_o = '0;
        if (en_i) begin
            row_we_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file: two registered read ports, one write port.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN;
// without it, a same-cycle read of the written register returns the old value.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = REGFILE_DATA_W,
    parameter int unsigned ADDR_W   = REGFILE_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic              read_en1,
    output logic [DATA_W-1:0] read_data1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic              read_en2,
    output logic [DATA_W-1:0] read_data2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write
);

    localparam int unsigned       Depth   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(REGFILE_ZERO_IDX);

    logic [DATA_W-1:0] mem_q [Depth];
    logic [Depth-1:0]  row_we_raw;
    logic [Depth-1:0]  row_we;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;

    regfile_wr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_wr_dec (
        .addr_i   (write_reg),
        .en_i     (reg_write & ~reset),
        .row_we_o (row_we_raw)
    );

    // Hard-wired zero register never accepts a write.
    always_comb begin
        row_we = row_we_raw;
        if (ZERO_REG != 0) begin
            row_we[REGFILE_ZERO_IDX] = 1'b0;
        end
    end

    // Register array: synchronous clear, otherwise write the decoded row.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (row_we[i]) begin
                    mem_q[i] <= write_data;
                end
            end
        end
    end

    // Read-port next state: hold when disabled, optional forwarding, zero-register override.
    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        if (read_en1) begin
            rd1_d = mem_q[read_reg1];
`ifdef REGFILE_BYPASS_EN
            if (reg_write && (read_reg1 == write_reg)) begin
                rd1_d = write_data;
            end
`endif
            if ((ZERO_REG != 0) && (read_reg1 == ZeroIdx)) begin
                rd1_d = '0;
            end
        end
        if (read_en2) begin
            rd2_d = mem_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
            if (reg_write && (read_reg2 == write_reg)) begin
                rd2_d = write_data;
            end
`endif
            if ((ZERO_REG != 0) && (read_reg2 == ZeroIdx)) begin
                rd2_d = '0;
            end
        end
    end

    // Registered read data; reset wins over read enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign read_data1 = rd1_q;
    assign read_data2 = rd2_q;

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised MIPS-style general-purpose register file: two read ports, one write port.
- Successor to the fixed 32x32 register array and its gate-level 5x32 write decoder.
- Width, depth and register-zero policy are parametrised.
- Reads are registered (1-cycle latency), with per-port read enables and an optional write-to-read bypass.
- Sits between instruction decode (register specifiers) and the ALU operand latches of the datapath.

Parameters:
DATA_W, 32, bit width of each register and of the data ports
ADDR_W, 5, register specifier width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is an ordinary register

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
read_reg1  input  ADDR_W  port-1 read specifier
read_en1  input  1  port-1 read enable
read_data1  output  DATA_W  port-1 registered read data
read_reg2  input  ADDR_W  port-2 read specifier
read_en2  input  1  port-2 read enable
read_data2  output  DATA_W  port-2 registered read data
write_reg  input  ADDR_W  write specifier
write_data  input  DATA_W  write data
reg_write  input  1  write enable

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset:
  - On a rising edge with reset=1, all 2**ADDR_W registers clear to 0; read_data1 and read_data2 clear to 0.
  - Reset overrides reg_write and read enables in the same cycle.
  - Reset asserted mid-sequence discards any write presented in that cycle.
- Write:
  - On a rising edge with reg_write=1 and reset=0, mem[write_reg] <= write_data.
  - With ZERO_REG=1 and write_reg=0, the write is dropped and the array is unchanged.
  - Write-enable selection is one-hot decoded from write_reg; exactly one or zero rows update per cycle.
- Read:
  - On a rising edge with read_enN=1, read_dataN <= mem[read_regN]; the value appears 1 cycle after the specifier is presented.
  - With read_enN=0, read_dataN holds its previous value.
  - With ZERO_REG=1 and read_regN=0, the registered value is 0 regardless of array contents.
  - Both ports are independent: same or different specifiers in the same cycle are both legal.
- Same-cycle read and write to the same register, without bypass:
  - The read captures the old array value (read-before-write).
  - The new value is visible on a read issued the following cycle.
- Widths: no arithmetic. Specifiers are used unsigned; every specifier value 0..2**ADDR_W-1 is legal, with no out-of-range case.
- No X on outputs after the first reset edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when the same edge has reg_write=1, read_enN=1 and read_regN==write_reg:
  - read_dataN <= write_data (write-through forwarding).
  - Not applied when ZERO_REG=1 and the specifier is 0; the output stays 0.
  - Not applied while reset=1.
- Undefined: read-before-write as described under Behaviour; no forwarding logic is synthesised.

Decomposition:
- Package regfile_pkg:
  - default constants REGFILE_DATA_W=32 and REGFILE_ADDR_W=5;
  - constant REGFILE_ZERO_IDX=0;
  - typedef for the register specifier (logic [REGFILE_ADDR_W-1:0]).
- Sub-module regfile_wr_decoder: parametrised ADDR_W to 2**ADDR_W one-hot decoder with enable. It replaces the cascaded 2x4/3x8/5x32 gate decoders. Inputs are write_reg and reg_write gated with ~reset; output is the row write-enable vector.
- Read muxes and the optional bypass compare stay in the top module.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5, then read r5 on port 1 next cycle -> read_data1=0xDEADBEEF one cycle after the read specifier is presented; read_data2 stays 0.
2. ZERO_REG=1: write 0x12345678 to r0, then read r0 on both ports -> both outputs 0. Repeat with ZERO_REG=0 -> both outputs 0x12345678.
3. Same-cycle write 0x0000AAAA to r7 and read r7 on port 2, with r7 previously 0x11 -> without REGFILE_BYPASS_EN read_data2=0x11, then 0x0000AAAA on the next read; with the macro read_data2=0x0000AAAA immediately.
4. Load r1=1 and r2=2, read r1 on port 1 with read_en1=1, then drop read_en1 and change read_reg1 to r2 for 3 cycles -> read_data1 holds 1 throughout; read_en1=1 gives 2 on the next edge.
5. Fill all 32 registers with value 0x100+index, assert reset for one cycle together with a write of 0xFFFF to r3 -> all registers read 0, including r3; outputs read 0 the cycle after reset.
6. Parametrised instance DATA_W=16, ADDR_W=3: write 0xBEEF to r7, read r7 and r6 on ports 1 and 2 -> 0xBEEF and 0x0000; the specifier wrap covers r0..r7 only.
